// File: rtl/tdc_readout_ctrl.sv
// TDC delay-line sequencer and read-out: launches shots, converts the thermometer code
// to a transition count, and accumulates sum/min/max/bubble over 2**LOG2_AVG shots.
module tdc_readout_ctrl #(
    parameter int N_DELAY    = 32,
    parameter int LOG2_AVG   = 3,
    parameter int SETTLE_CYC = 2,
    parameter int CW         = $clog2(N_DELAY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_DELAY-1:0]     thermo_in,
    output logic                   start_out,
    output logic [CW+LOG2_AVG-1:0] result_sum,
    output logic [CW-1:0]          result_min,
    output logic [CW-1:0]          result_max,
    output logic                   result_bubble,
    output logic                   result_valid,
    input  logic                   result_ready
);
    // state    | meaning
    // S_IDLE   | waiting for en; accumulators held at their window-start values
    // S_LAUNCH | start pulse to the delay line (one cycle)
    // S_SETTLE | SETTLE_CYC cycles for the line to settle
    // S_SAMPLE | capture one shot and fold it into the accumulators
    // S_HOLD   | result presented until the host accepts it
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_SAMPLE,
        S_HOLD
    } state_t;

    localparam int SW     = CW + LOG2_AVG;
    localparam int SHOT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int SCW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SHOT_W-1:0] LAST_SHOT = SHOT_W'((1 << LOG2_AVG) - 1);

    state_t            state_q, state_d;
    logic [SCW-1:0]    settle_q, settle_d;
    logic [SHOT_W-1:0] shot_q, shot_d;
    logic [SW-1:0]     sum_q, sum_d;
    logic [CW-1:0]     min_q, min_d;
    logic [CW-1:0]     max_q, max_d;
    logic              bub_q, bub_d;
    logic [SW-1:0]     res_sum_q, res_sum_d;
    logic [CW-1:0]     res_min_q, res_min_d;
    logic [CW-1:0]     res_max_q, res_max_d;
    logic              res_bub_q, res_bub_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;

    logic [CW-1:0]     shot_cnt;
    logic              shot_bub;

    // Popcount rather than first-zero search, so bubbles still count every captured one.
    always_comb begin
        shot_cnt = '0;
        shot_bub = 1'b0;
        for (int i = 0; i < N_DELAY; i++) begin
            shot_cnt = shot_cnt + CW'(thermo_in[i]);
        end
        for (int i = 0; i < N_DELAY - 1; i++) begin
            if (!thermo_in[i] && thermo_in[i+1]) begin
                shot_bub = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        shot_d    = shot_q;
        sum_d     = sum_q;
        min_d     = min_q;
        max_d     = max_q;
        bub_d     = bub_q;
        res_sum_d = res_sum_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_bub_d = res_bub_q;
        case (state_q)
            S_IDLE: begin
                shot_d = '0;
                sum_d  = '0;
                min_d  = CW'(N_DELAY);
                max_d  = '0;
                bub_d  = 1'b0;
                if (en) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                settle_d = SCW'(SETTLE_CYC - 1);
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                sum_d = sum_q + SW'(shot_cnt);
                min_d = (shot_cnt < min_q) ? shot_cnt : min_q;
                max_d = (shot_cnt > max_q) ? shot_cnt : max_q;
                bub_d = bub_q | shot_bub;
                if (shot_q == LAST_SHOT) begin
                    res_sum_d = sum_d;
                    res_min_d = min_d;
                    res_max_d = max_d;
                    res_bub_d = bub_d;
                    state_d   = S_HOLD;
                end else begin
                    shot_d  = shot_q + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_HOLD: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered from the next state so both track the FSM without a cycle of lag.
        start_d = (state_d == S_LAUNCH);
        valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            settle_q  <= '0;
            shot_q    <= '0;
            sum_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            bub_q     <= 1'b0;
            res_sum_q <= '0;
            res_min_q <= '0;
            res_max_q <= '0;
            res_bub_q <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            shot_q    <= shot_d;
            sum_q     <= sum_d;
            min_q     <= min_d;
            max_q     <= max_d;
            bub_q     <= bub_d;
            res_sum_q <= res_sum_d;
            res_min_q <= res_min_d;
            res_max_q <= res_max_d;
            res_bub_q <= res_bub_d;
            valid_q   <= valid_d;
            start_q   <= start_d;
        end
    end

    assign start_out     = start_q;
    assign result_sum    = res_sum_q;
    assign result_min    = res_min_q;
    assign result_max    = res_max_q;
    assign result_bubble = res_bub_q;
    assign result_valid  = valid_q;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Scoreboard bench for tdc_readout_ctrl: directed windows push hand-computed results,
// a negedge monitor pops and compares on every result handshake.
module tb_tdc_readout_ctrl;
    localparam int N_DELAY = 32;
    localparam int LOG2_AVG = 3;
    localparam int SETTLE_CYC = 2;
    localparam int CW = 6;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [N_DELAY-1:0]     thermo_in;
    logic                   start_out;
    logic [CW+LOG2_AVG-1:0] result_sum;
    logic [CW-1:0]          result_min;
    logic [CW-1:0]          result_max;
    logic                   result_bubble;
    logic                   result_valid;
    logic                   result_ready;

    typedef struct {
        int sum;
        int mn;
        int mx;
        int bub;
    } exp_t;

    exp_t queue_exp[$];
    logic [31:0] codes [8];
    int n_cmp = 0;
    int n_err = 0;

    tdc_readout_ctrl #(
        .N_DELAY   (N_DELAY),
        .LOG2_AVG  (LOG2_AVG),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .thermo_in    (thermo_in),
        .start_out    (start_out),
        .result_sum   (result_sum),
        .result_min   (result_min),
        .result_max   (result_max),
        .result_bubble(result_bubble),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int mn, input int mx, input int b);
        exp_t e;
        e.sum = s; e.mn = mn; e.mx = mx; e.bub = b;
        queue_exp.push_back(e);
    endtask

    task automatic fill(input logic [31:0] c);
        for (int i = 0; i < 8; i++) codes[i] = c;
    endtask

    // Monitor: every accepted result is checked against the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && result_valid && result_ready) begin
            if (queue_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: sum %0d presented with no window pending", result_sum);
            end else begin
                exp_t e;
                e = queue_exp.pop_front();
                chk("result_sum", int'(result_sum), e.sum);
                chk("result_min", int'(result_min), e.mn);
                chk("result_max", int'(result_max), e.mx);
                chk("result_bubble", int'(result_bubble), e.bub);
            end
        end
    end

    // Runs one window, driving codes[n] after the n-th launch pulse; returns once result_valid
    // is seen. abort_at>0 asserts rst right after that many pulses instead.
    task automatic run_window(input int abort_at);
        int n, c0, cv, last, sp_err;
        bit done;
        n = 0; c0 = -1; cv = -1; last = -1; sp_err = 0; done = 0;
        en = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            tick();
            if (start_out) begin
                if (n < 8) thermo_in = codes[n];
                if (n == 0) begin
                    c0 = c;
                    en = 1'b0;
                end else if (c - last != 2 + SETTLE_CYC) begin
                    sp_err++;
                end
                last = c;
                n++;
                if (abort_at > 0 && n == abort_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_start_out", int'(start_out), 0);
                    chk("rst_valid", int'(result_valid), 0);
                    chk("rst_sum", int'(result_sum), 0);
                    chk("rst_min", int'(result_min), 0);
                    chk("rst_max", int'(result_max), 0);
                    chk("rst_bubble", int'(result_bubble), 0);
                    return;
                end
            end
            if (result_valid) begin
                cv = c;
                done = 1'b1;
            end
        end
        chk("window_done", int'(done), 1);
        chk("pulse_count", n, 8);
        chk("pulse_spacing_errs", sp_err, 0);
        chk("valid_latency", cv - c0, (2 + SETTLE_CYC) * 8);
    endtask

    initial begin
        int unstable, pulses;
        logic [CW+LOG2_AVG-1:0] s0;
        logic [CW-1:0] mn0, mx0;
        logic b0;

        rst = 1'b1; en = 1'b0; thermo_in = '0; result_ready = 1'b1;
        repeat (3) tick();
        chk("reset_start_out", int'(start_out), 0);
        chk("reset_valid", int'(result_valid), 0);
        chk("reset_sum", int'(result_sum), 0);
        chk("reset_min", int'(result_min), 0);
        chk("reset_max", int'(result_max), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_no_start", int'(start_out), 0);

        // 1: all-zero code
        fill(32'h0000_0000);
        push(0, 0, 0, 0);
        run_window(0);
        tick();
        chk("valid_drop_1", int'(result_valid), 0);

        // 2: constant half-scale code; results persist after the handshake
        fill(32'h0000_FFFF);
        push(128, 16, 16, 0);
        run_window(0);
        tick();
        chk("valid_drop_2", int'(result_valid), 0);
        repeat (3) tick();
        chk("sum_kept_after_hs", int'(result_sum), 128);
        chk("no_restart_en0", int'(start_out), 0);

        // 3: one bubbled shot
        fill(32'h0000_00FF);
        codes[3] = 32'h0000_FF7F;
        push(71, 8, 15, 1);
        run_window(0);
        tick();

        // 4: backpressure with a ramp of counts 1..8
        codes[0] = 32'h1;  codes[1] = 32'h3;  codes[2] = 32'h7;  codes[3] = 32'hF;
        codes[4] = 32'h1F; codes[5] = 32'h3F; codes[6] = 32'h7F; codes[7] = 32'hFF;
        push(36, 1, 8, 0);
        result_ready = 1'b0;
        run_window(0);
        s0 = result_sum; mn0 = result_min; mx0 = result_max; b0 = result_bubble;
        unstable = 0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (result_sum !== s0 || result_min !== mn0 || result_max !== mx0 ||
                result_bubble !== b0 || result_valid !== 1'b1) unstable++;
            if (start_out) pulses++;
        end
        chk("hold_unstable_cycles", unstable, 0);
        chk("hold_start_pulses", pulses, 0);
        result_ready = 1'b1;
        tick();
        chk("valid_drop_4", int'(result_valid), 0);

        // 5: full scale
        fill(32'hFFFF_FFFF);
        push(256, 32, 32, 0);
        run_window(0);
        tick();

        // 6: reset during shot 5, then a fresh window
        fill(32'h0000_0000);
        run_window(5);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_valid", int'(result_valid), 0);
        fill(32'h0000_03FF);
        push(80, 10, 10, 0);
        run_window(0);
        tick();

        repeat (5) tick();
        chk("scoreboard_left", queue_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
